// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous RAM port between the CPU load/store path and a host loader,
// CPU first, with a starvation counter that guarantees the host a beat after HOST_WAIT_MAX refusals.
module dmem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int HOST_WAIT_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_stall,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_wren,
  output logic          o_mem_rden,
  input  logic [DW-1:0] i_mem_q
);
  localparam logic [3:0] HWM = 4'(HOST_WAIT_MAX);
  logic [3:0]    r_hwait;
  logic          r_rd_pending, r_rd_owner;
  logic [DW-1:0] r_cpu_hold, r_host_hold;
  logic          w_host_gnt, w_cpu_gnt, w_any_gnt, w_we;
  // grants are suppressed while reset is held so nothing reaches the RAM
  assign w_host_gnt    = ~rst & i_host_req & (~i_cpu_req | (r_hwait == HWM));
  assign w_cpu_gnt     = ~rst & i_cpu_req & ~w_host_gnt;
  assign w_any_gnt     = w_cpu_gnt | w_host_gnt;
  assign w_we          = w_cpu_gnt ? i_cpu_we : i_host_we;
  assign o_cpu_gnt     = w_cpu_gnt;
  assign o_host_gnt    = w_host_gnt;
  assign o_cpu_stall   = i_cpu_req & ~w_cpu_gnt;
  assign o_mem_addr    = w_cpu_gnt ? i_cpu_addr : w_host_gnt ? i_host_addr : '0;
  assign o_mem_wdata   = w_cpu_gnt ? i_cpu_wdata : w_host_gnt ? i_host_wdata : '0;
  assign o_mem_wren    = w_any_gnt & w_we;
  assign o_mem_rden    = w_any_gnt & ~w_we;
  assign o_cpu_rvalid  = r_rd_pending & ~r_rd_owner;
  assign o_host_rvalid = r_rd_pending & r_rd_owner;
  assign o_cpu_rdata   = o_cpu_rvalid ? i_mem_q : r_cpu_hold;
  assign o_host_rdata  = o_host_rvalid ? i_mem_q : r_host_hold;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hwait      <= '0;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_cpu_hold   <= '0;
      r_host_hold  <= '0;
    end else begin
      r_hwait      <= (i_host_req & ~w_host_gnt) ? ((r_hwait == HWM) ? r_hwait : r_hwait + 4'd1) : 4'd0;
      r_rd_pending <= o_mem_rden;
      r_rd_owner   <= w_host_gnt;
      if (o_cpu_rvalid) r_cpu_hold <= i_mem_q;
      if (o_host_rvalid) r_host_hold <= i_mem_q;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed bench; a behavioural model predicts every output each cycle.
module tb_dmem_arbiter;
  localparam int AW = 16, DW = 16, HWM = 3;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] cpu_addr = 0, host_addr = 0;
  logic [DW-1:0] cpu_wdata = 0, host_wdata = 0;
  logic cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_wren, mem_rden;
  logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_q;
  logic [AW-1:0] mem_addr;
  int checks = 0, errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .HOST_WAIT_MAX(HWM)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren), .o_mem_rden(mem_rden),
    .i_mem_q(mem_q));

  always #5 clk = ~clk;

  // RAM behind the DUT: 1-cycle read latency
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_rden) mem_q <= ram[mem_addr[7:0]];
  end

  // reference model state
  logic [DW-1:0] sh [0:255];
  int m_wait = 0;
  bit m_pend = 0, m_owner = 0, m_cg = 0, m_hg = 0;
  logic [DW-1:0] m_data = 0, m_hold_c = 0, m_hold_h = 0;

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  task automatic model_check();
    bit eh, ec, erc, erh;
    eh = !rst && host_req && (!cpu_req || m_wait >= HWM);
    ec = !rst && cpu_req && !eh;
    erc = !rst && m_pend && !m_owner;
    erh = !rst && m_pend && m_owner;
    m_cg = ec;
    m_hg = eh;
    cmp("cpu_gnt", cpu_gnt, ec);
    cmp("host_gnt", host_gnt, eh);
    cmp("cpu_stall", cpu_stall, cpu_req && !ec);
    cmp("mem_addr", mem_addr, ec ? cpu_addr : eh ? host_addr : 0);
    cmp("mem_wdata", mem_wdata, ec ? cpu_wdata : eh ? host_wdata : 0);
    cmp("mem_wren", mem_wren, (ec && cpu_we) || (eh && host_we));
    cmp("mem_rden", mem_rden, (ec && !cpu_we) || (eh && !host_we));
    cmp("cpu_rvalid", cpu_rvalid, erc);
    cmp("host_rvalid", host_rvalid, erh);
    cmp("cpu_rdata", cpu_rdata, rst ? 0 : erc ? m_data : m_hold_c);
    cmp("host_rdata", host_rdata, rst ? 0 : erh ? m_data : m_hold_h);
  endtask

  task automatic step();
    logic [7:0] a;
    bit we;
    if (rst) begin
      m_wait = 0; m_pend = 0; m_owner = 0; m_hold_c = 0; m_hold_h = 0; m_cg = 0; m_hg = 0;
      return;
    end
    if (m_pend) begin
      if (m_owner) m_hold_h = m_data;
      else m_hold_c = m_data;
    end
    m_pend = 0;
    if (m_cg || m_hg) begin
      a = m_cg ? cpu_addr[7:0] : host_addr[7:0];
      we = m_cg ? cpu_we : host_we;
      if (we) sh[a] = m_cg ? cpu_wdata : host_wdata;
      else begin
        m_pend = 1;
        m_data = sh[a];
        m_owner = m_hg;
      end
    end
    m_wait = (host_req && !m_hg) ? ((m_wait + 1 > HWM) ? HWM : m_wait + 1) : 0;
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; host_req = 0;
    settle(); adv();
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    ram[a] = d;
    sh[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 0; sh[i] = 0; end
    mem_q = 0;
    settle();
    cmp("reset_gnt", {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wren, mem_rden}, 0);
    cmp("reset_data", {cpu_rdata, host_rdata}, 0);
    adv();
    rst = 0;
    preload(8'h10, 16'hBEEF);
    preload(8'h01, 16'hAAAA);
    preload(8'h02, 16'h5555);
    idle();
    // CPU-only read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    settle(); cmp("t1_gnt", cpu_gnt, 1); adv();
    cpu_req = 0;
    settle(); cmp("t1_rvalid", cpu_rvalid, 1); cmp("t1_rdata", cpu_rdata, 16'hBEEF); adv();
    settle(); cmp("t1_hold", cpu_rdata, 16'hBEEF); cmp("t1_rv0", cpu_rvalid, 0); adv();
    // host write then read
    host_req = 1; host_we = 1; host_addr = 16'h0020; host_wdata = 16'h1234;
    settle(); cmp("t2_wren", mem_wren, 1); adv();
    host_we = 0;
    settle(); cmp("t2_wren0", mem_wren, 0); cmp("t2_rden", mem_rden, 1); adv();
    host_req = 0;
    settle(); cmp("t2_rvalid", host_rvalid, 1); cmp("t2_rdata", host_rdata, 16'h1234);
    cmp("t2_cpu_rv", cpu_rvalid, 0); adv();
    idle();
    // continuous conflict
    cpu_req = 1; cpu_addr = 1; host_req = 1; host_addr = 2;
    for (int c = 0; c < 8; c++) begin
      settle();
      cmp($sformatf("t3_hgnt%0d", c), host_gnt, (c == 3 || c == 7));
      cmp($sformatf("t3_stall%0d", c), cpu_stall, (c == 3 || c == 7));
      adv();
    end
    idle();
    // host drops request mid-conflict
    for (int c = 0; c < 8; c++) begin
      cpu_req = 1; host_req = (c != 2);
      settle();
      cmp($sformatf("t4_hgnt%0d", c), host_gnt, (c == 6));
      adv();
    end
    idle();
    // alternating reads
    for (int c = 0; c < 7; c++) begin
      cpu_req = (c < 6) && (c % 2 == 0); host_req = (c < 6) && (c % 2 == 1);
      cpu_addr = 1; host_addr = 2; cpu_we = 0; host_we = 0;
      settle();
      if (c > 0) begin
        cmp($sformatf("t5_crv%0d", c), cpu_rvalid, (c % 2 == 1));
        cmp($sformatf("t5_hrv%0d", c), host_rvalid, (c % 2 == 0));
        cmp($sformatf("t5_data%0d", c), (c % 2 == 1) ? cpu_rdata : host_rdata, (c % 2 == 1) ? 16'hAAAA : 16'h5555);
      end
      adv();
    end
    idle();
    // reset during read return
    preload(8'h10, 16'hBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    settle(); adv();
    rst = 1;
    settle(); cmp("t6_rv", cpu_rvalid, 0); cmp("t6_rdata", cpu_rdata, 0); cmp("t6_gnt", cpu_gnt | host_gnt, 0);
    adv();
    rst = 0; cpu_req = 0;
    settle(); cmp("t6_rv_after", cpu_rvalid, 0); cmp("t6_rdata_after", cpu_rdata, 0); adv();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req || m_cg) begin
        cpu_req = $urandom_range(0, 2) != 0; cpu_we = $urandom_range(0, 2) == 0;
        cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
      end
      if (!host_req || m_hg) begin
        host_req = $urandom_range(0, 1) != 0; host_we = $urandom_range(0, 1) != 0;
        host_addr = 16'($urandom_range(0, 15)); host_wdata = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) host_req = 0;
      rst = $urandom_range(0, 399) == 0;
      settle(); adv();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
